wb_commit_unit: RTL

Write-back commit stage that sits directly upstream of the register file's write port (`wr_en`/`a3`/`din`). It merges single-cycle ALU results with in-order load responses returning from data memory, and drives one register write per cycle. It also keeps a tag FIFO of outstanding load destinations, which gives the issue logic per-register busy flags for RAW/WAW stalls. Output write signals are registered on `posedge clk`; the register file commits them on the following `negedge`.

---
 rtl/wb_commit_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/wb_commit_unit.sv
// Write-back commit stage: merges single-cycle ALU results with in-order load
// responses into one registered register-file write per cycle. A tag FIFO of
// outstanding load destinations provides per-register busy flags for RAW/WAW stalls.
// Optional feature macro: WB_STALL_CNT_EN adds a 32-bit ALU stall counter output.
module wb_commit_unit #(
    parameter int unsigned D_WIDTH       = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned LD_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd_i,
    input  logic [D_WIDTH-1:0]       alu_data_i,
    output logic                     alu_ready_o,
    input  logic                     ld_issue_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] ld_issue_rd_i,
    output logic                     ld_full_o,
    input  logic                     ld_resp_valid_i,
    input  logic [D_WIDTH-1:0]       ld_resp_data_i,
    input  logic [ADDRESS_WIDTH-1:0] rs1_i,
    input  logic [ADDRESS_WIDTH-1:0] rs2_i,
    output logic                     busy1_o,
    output logic                     busy2_o,
    output logic                     wr_en_o,
    output logic [ADDRESS_WIDTH-1:0] a3_o,
    output logic [D_WIDTH-1:0]       din_o
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt_o
`endif
);

    localparam int unsigned PtrW    = $clog2(LD_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;

    // Tag FIFO state
    logic [ADDRESS_WIDTH-1:0] tag_q [LD_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]          cnt_q, cnt_d;

    // Skid buffer state
    logic                     skid_valid_q, skid_valid_d;
    logic [ADDRESS_WIDTH-1:0] skid_rd_q, skid_rd_d;
    logic [D_WIDTH-1:0]       skid_data_q, skid_data_d;

    // Registered write port
    logic                     wr_en_q, wr_en_d;
    logic [ADDRESS_WIDTH-1:0] a3_q, a3_d;
    logic [D_WIDTH-1:0]       din_q, din_d;

    logic [NumRegs-1:0]       busy_vec;
    logic [PtrW-1:0]          scan_idx;
    logic                     push, pop, alu_acc;

    logic                     sel_en;
    logic [ADDRESS_WIDTH-1:0] sel_rd;
    logic [D_WIDTH-1:0]       sel_data;

    // Busy vector: OR of destinations of every valid FIFO entry, x0 never busy
    always_comb begin
        busy_vec = '0;
        scan_idx = '0;
        for (int i = 0; i < int'(LD_DEPTH); i++) begin
            scan_idx = rd_ptr_q + PtrW'(i);
            if (i < int'(cnt_q)) begin
                busy_vec[tag_q[scan_idx]] = 1'b1;
            end
        end
        busy_vec[0] = 1'b0;
    end

    assign busy1_o     = busy_vec[rs1_i];
    assign busy2_o     = busy_vec[rs2_i];
    assign ld_full_o   = (cnt_q == CntW'(LD_DEPTH));
    // Only registered state and alu_rd feed this; no path from ld_resp_valid
    assign alu_ready_o = !skid_valid_q && !busy_vec[alu_rd_i];

    assign alu_acc = alu_valid_i && alu_ready_o;
    assign pop     = ld_resp_valid_i && (cnt_q != '0);
    // A full FIFO still accepts an issue when an entry pops in the same cycle
    assign push    = ld_issue_valid_i && (!ld_full_o || pop);

    // Occupancy count next state
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Tag FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LD_DEPTH); i++) begin
                tag_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= ld_issue_rd_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    // Source arbitration: load response > skid entry > new ALU result
    always_comb begin
        sel_en       = 1'b0;
        sel_rd       = a3_q;
        sel_data     = din_q;
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        if (pop) begin
            sel_en   = 1'b1;
            sel_rd   = tag_q[rd_ptr_q];
            sel_data = ld_resp_data_i;
            // ALU result that lost arbitration parks in the skid; x0 results are dropped
            if (alu_acc && (alu_rd_i != '0)) begin
                skid_valid_d = 1'b1;
                skid_rd_d    = alu_rd_i;
                skid_data_d  = alu_data_i;
            end
        end else if (skid_valid_q) begin
            sel_en       = 1'b1;
            sel_rd       = skid_rd_q;
            sel_data     = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (alu_acc) begin
            sel_en   = 1'b1;
            sel_rd   = alu_rd_i;
            sel_data = alu_data_i;
        end
        wr_en_d = sel_en && (sel_rd != '0);
        a3_d    = sel_rd;
        din_d   = sel_data;
    end

    // Skid buffer and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            wr_en_q      <= 1'b0;
            a3_q         <= '0;
            din_q        <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            wr_en_q      <= wr_en_d;
            a3_q         <= a3_d;
            din_q        <= din_d;
        end
    end

    assign wr_en_o = wr_en_q;
    assign a3_o    = a3_q;
    assign din_o   = din_q;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles where an ALU result is presented but refused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (alu_valid_i && !alu_ready_o) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
